sbox_share_ctrl: RTL and testbench
==================================

SBOX_SHARE_CTRL -- requirements
Module: sbox_share_ctrl

Interface
REQ-001 Parameters: none; the word count is fixed at 4 and the word width at 32 bits.
REQ-002 CLK  in  1  sole clock; all state updates on the rising edge.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 ST_REQ  in  1  cipher-state substitution request; level, held until ST_ACK.
REQ-005 ST_DATA  in  128  state to substitute; sampled on the edge where ST_ACK=1.
REQ-006 ST_ACK  out  1  combinational grant/accept pulse for ST.
REQ-007 ST_VALID  out  1  one-cycle pulse; ST_RESULT is new this cycle.
REQ-008 ST_RESULT  out  128  SubBytes(ST_DATA); holds until the next ST completion.
REQ-009 KS_REQ  in  1  key-schedule SubWord request; level, held until KS_ACK.
REQ-010 KS_WORD  in  32  word to substitute; sampled on the edge where KS_ACK=1.
REQ-011 KS_ACK  out  1  combinational grant/accept pulse for KS.
REQ-012 KS_VALID  out  1  one-cycle pulse; KS_RESULT is new this cycle.
REQ-013 KS_RESULT  out  32  SubWord(KS_WORD); holds until the next KS completion.
REQ-014 BUSY  out  1  high whenever the FSM is not in IDLE.

Function
REQ-015 A single 32-bit substitution slice (4 S-boxes) SHALL be shared by both requesters; at most one job is in flight.
REQ-016 FSM states: IDLE, ST_RUN, KS_RUN.
- IDLE->ST_RUN on an ST grant.
- IDLE->KS_RUN on a KS grant.
- KS_RUN->IDLE after 1 cycle.
- ST_RUN->IDLE after word index 3.
REQ-017 Grants SHALL be issued only in IDLE, and only while RST=0.
- ACK = grant, combinational from REQ, state and LAST.
- ACK is never high outside IDLE.
REQ-018 Arbitration SHALL be round-robin via the 1-bit register LAST (0=ST, 1=KS), updated on every grant.
- Only one requester active: that requester wins.
- Both active: the side opposite LAST wins.
REQ-019 ST job, ACK in cycle t:
- ST_DATA is captured at the end of t.
- Cycles t+1..t+4 substitute words 0..3, word 0 = bits [127:96] (MSW first), one word per cycle, written into the matching slice of the result register.
- ST_VALID=1 in t+5; ST_RESULT is updated in the same cycle.
REQ-020 KS job, ACK in cycle t: KS_RUN in t+1; KS_VALID=1 and KS_RESULT updated in t+2.
REQ-021 The FSM is back in IDLE in the VALID cycle and SHALL accept a new grant in that same cycle.
- Peak throughput: one ST job per 5 cycles, one KS job per 2 cycles.
REQ-022 A requester that keeps REQ high after ACK is treated as issuing a new request.
REQ-023 Requests and input data changes SHALL be ignored while BUSY=1; no queuing.
REQ-024 ST_RESULT SHALL NOT be visible as partially updated: the ST result register drives ST_RESULT only on completion, through a separate working register.

Reset
REQ-025 On RST=1 at a clock edge:
- state=IDLE, LAST=1.
- ST_VALID=0, KS_VALID=0, BUSY=0.
- ST_RESULT=0, KS_RESULT=0, working register=0, word index=0.
REQ-026 ST_ACK and KS_ACK SHALL be 0 in any cycle where RST=1.
REQ-027 Reset mid-job SHALL abort the job with no VALID pulse; the first tie after reset goes to ST.

Structure
REQ-028 Shared package aes_pkg SHALL hold:
- FSM state encoding.
- NUM_WORDS=4 and WORD_W=32.
- The S-box function.
REQ-029 One sub-module, sub_word, SHALL be instantiated exactly once: combinational, 32-bit in/out, 4 S-box lookups.

Verification
REQ-030 ST only: ST_DATA=00112233445566778899aabbccddeeff -> ST_ACK at t, ST_VALID only at t+5, ST_RESULT=638293c31bfc33f5c4eeacea4bc12816.
REQ-031 KS only: KS_WORD=cf4f3c09 -> KS_VALID at t+2, KS_RESULT=8a84eb01.
REQ-032 Tie after reset: both REQ high -> ST granted first; KS granted in ST_VALID cycle; next tie goes to ST; no ACK while BUSY.
REQ-033 Back-to-back KS with REQ held -> ACKs every 2 cycles, each KS_VALID one cycle wide, ST never starved when also requesting.
REQ-034 RST asserted at t+2 of an ST job -> no ST_VALID, all outputs 0 next cycle, BUSY=0.
REQ-035 ST_DATA changed while BUSY -> ST_RESULT reflects only the captured value; all-zero input -> 63636363636363636363636363636363.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions for the S-box sharing controller.
// Holds the controller FSM state type, the word geometry and the forward
// AES S-box lookup used by sub_word.
package aes_pkg;

   localparam int unsigned NUM_WORDS = 4;
   localparam int unsigned WORD_W    = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ST_RUN = 2'd1,
      KS_RUN = 2'd2
   } state_t;

   // Row 0 of the usual 16x16 table is leftmost, so entry b sits at index 255-b.
   localparam logic [255:0][7:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TABLE[~b];
   endfunction

endpackage

// File: rtl/sub_word.sv
// Combinational SubWord: four parallel AES S-box lookups on a 32-bit word.
// Ports:
//   word   - 32-bit input word
//   result - byte-wise S-box substitution of word
module sub_word
   import aes_pkg::*;
(
   input  logic [WORD_W-1:0] word,
   output logic [WORD_W-1:0] result
);

   always_comb begin
      result = '0;
      for (int unsigned i = 0; i < WORD_W / 8; i++) begin
         result[i*8 +: 8] = sbox(word[i*8 +: 8]);
      end
   end

endmodule

// File: rtl/sbox_share_ctrl.sv
// Shares one 32-bit SubWord slice between the cipher-state SubBytes path (ST)
// and the key-schedule SubWord path (KS). One job in flight at a time,
// round-robin arbitration on ties.
// Ports:
//   CLK, RST            - clock, synchronous active-high reset
//   ST_REQ/ST_DATA      - 128-bit state substitution request (level)
//   ST_ACK              - combinational grant for ST
//   ST_VALID/ST_RESULT  - one-cycle completion pulse / SubBytes result
//   KS_REQ/KS_WORD      - 32-bit SubWord request (level)
//   KS_ACK              - combinational grant for KS
//   KS_VALID/KS_RESULT  - one-cycle completion pulse / SubWord result
//   BUSY                - high whenever a job is in flight
module sbox_share_ctrl
   import aes_pkg::*;
(
   input  logic         CLK,
   input  logic         RST,
   input  logic         ST_REQ,
   input  logic [127:0] ST_DATA,
   output logic         ST_ACK,
   output logic         ST_VALID,
   output logic [127:0] ST_RESULT,
   input  logic         KS_REQ,
   input  logic [31:0]  KS_WORD,
   output logic         KS_ACK,
   output logic         KS_VALID,
   output logic [31:0]  KS_RESULT,
   output logic         BUSY
);

   localparam logic [1:0] LAST_WORD = 2'(NUM_WORDS - 1);

   state_t state, state_nxt;
   logic   last;                                 // 0: ST won last grant, 1: KS
   logic [1:0] widx;
   logic [NUM_WORDS-1:0][WORD_W-1:0] work;       // work[3] is word 0 (MSW)
   logic [NUM_WORDS-1:0][WORD_W-1:0] work_merged;
   logic [WORD_W-1:0] ks_word_q;
   logic [WORD_W-1:0] sub_in;
   logic [WORD_W-1:0] sub_out;

   sub_word u_sub_word (
      .word   (sub_in),
      .result (sub_out)
   );

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      ST_ACK      = 1'b0;
      KS_ACK      = 1'b0;
      BUSY        = (state != IDLE);
      sub_in      = ks_word_q;
      work_merged = work;
      case (state)
         IDLE: begin
            if (!RST) begin
               ST_ACK = ST_REQ && (!KS_REQ || last);
               KS_ACK = KS_REQ && !ST_ACK;
            end
            if (ST_ACK)      state_nxt = ST_RUN;
            else if (KS_ACK) state_nxt = KS_RUN;
         end
         ST_RUN: begin
            // word index i lives in work[3-i], i.e. work[~widx]
            sub_in            = work[~widx];
            work_merged[~widx] = sub_out;
            if (widx == LAST_WORD) state_nxt = IDLE;
         end
         KS_RUN:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         last      <= 1'b1;
         widx      <= '0;
         work      <= '0;
         ks_word_q <= '0;
         ST_RESULT <= '0;
         KS_RESULT <= '0;
         ST_VALID  <= 1'b0;
         KS_VALID  <= 1'b0;
      end else begin
         ST_VALID <= 1'b0;
         KS_VALID <= 1'b0;
         if (ST_ACK) begin
            last <= 1'b0;
            work <= ST_DATA;
            widx <= '0;
         end else if (KS_ACK) begin
            last      <= 1'b1;
            ks_word_q <= KS_WORD;
         end
         case (state)
            ST_RUN: begin
               work <= work_merged;
               widx <= widx + 2'd1;
               // ST_RESULT only ever sees the fully substituted state
               if (widx == LAST_WORD) begin
                  ST_RESULT <= work_merged;
                  ST_VALID  <= 1'b1;
               end
            end
            KS_RUN: begin
               KS_RESULT <= sub_out;
               KS_VALID  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Self-checking bench for sbox_share_ctrl: directed vectors plus randomized
// traffic, compared every cycle against a job-level reference model that
// computes the S-box from GF(2^8) inversion and the AES affine map.
module tb_sbox_share_ctrl;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         st_req = 1'b0;
   logic [127:0] st_data = '0;
   logic         ks_req = 1'b0;
   logic [31:0]  ks_word = '0;
   logic         st_ack, st_valid, ks_ack, ks_valid, busy;
   logic [127:0] st_result;
   logic [31:0]  ks_result;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   sbox_share_ctrl dut (
      .CLK       (clk),
      .RST       (rst),
      .ST_REQ    (st_req),
      .ST_DATA   (st_data),
      .ST_ACK    (st_ack),
      .ST_VALID  (st_valid),
      .ST_RESULT (st_result),
      .KS_REQ    (ks_req),
      .KS_WORD   (ks_word),
      .KS_ACK    (ks_ack),
      .KS_VALID  (ks_valid),
      .KS_RESULT (ks_result),
      .BUSY      (busy)
   );

   // ---------------- reference S-box from GF(2^8) arithmetic ----------------
   logic [7:0] sb_tab [256];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] calc_sbox(input logic [7:0] x);
      logic [7:0] inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);   // x^254 = x^-1, 0 -> 0
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] ref_sub(input logic [127:0] v, input int nbytes);
      logic [127:0] r = '0;
      for (int i = 0; i < nbytes; i++) r[i*8 +: 8] = sb_tab[v[i*8 +: 8]];
      return r;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // ---------------- job-level reference model ----------------
   int           m_left;        // cycles the current job still occupies the slice
   bit           m_is_st;
   bit           m_last;
   logic [127:0] m_st_cap, m_st_res;
   logic [31:0]  m_ks_cap, m_ks_res;
   bit           m_st_valid, m_ks_valid;
   bit           g_st, g_ks;

   task automatic model_reset();
      m_left = 0; m_is_st = 0; m_last = 1;
      m_st_cap = '0; m_st_res = '0; m_ks_cap = '0; m_ks_res = '0;
      m_st_valid = 0; m_ks_valid = 0;
   endtask

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
   task automatic step(input bit r, input bit sr, input logic [127:0] sd,
                       input bit kr, input logic [31:0] kw);
      rst = r; st_req = sr; st_data = sd; ks_req = kr; ks_word = kw;
      g_st = 0; g_ks = 0;
      if (!r && m_left == 0) begin
         if (sr && kr) begin
            g_st = m_last;          // winner is the side that did not win last
            g_ks = !m_last;
         end else begin
            g_st = sr;
            g_ks = kr;
         end
      end
      #4;
      check("st_ack",    st_ack,    g_st);
      check("ks_ack",    ks_ack,    g_ks);
      check("busy",      busy,      m_left != 0);
      check("st_valid",  st_valid,  m_st_valid);
      check("ks_valid",  ks_valid,  m_ks_valid);
      check("st_result", st_result, m_st_res);
      check("ks_result", ks_result, m_ks_res);
      if (r) begin
         model_reset();
      end else begin
         m_st_valid = 0;
         m_ks_valid = 0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               if (m_is_st) begin
                  m_st_res = ref_sub(m_st_cap, 16);
                  m_st_valid = 1;
               end else begin
                  m_ks_res = 32'(ref_sub({96'h0, m_ks_cap}, 4));
                  m_ks_valid = 1;
               end
            end
         end else if (g_st) begin
            m_left = 4; m_is_st = 1; m_st_cap = sd; m_last = 0;
         end else if (g_ks) begin
            m_left = 1; m_is_st = 0; m_ks_cap = kw; m_last = 1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit           sr, kr, r;
      logic [127:0] sd;
      logic [31:0]  kw;

      for (int i = 0; i < 256; i++) sb_tab[i] = calc_sbox(8'(i));
      model_reset();

      @(posedge clk);
      #1;
      step(1, 0, '0, 0, '0);

      // ST vector; data scrambled once busy
      sr = 1; sd = 128'h00112233445566778899aabbccddeeff;
      repeat (7) begin
         step(0, sr, sd, 0, '0);
         if (g_st) sr = 0;
         if (g_st || m_left > 0) sd = rand128();
      end
      check("st_vector", st_result, 128'h638293c31bfc33f5c4eeacea4bc12816);

      // KS vector
      kr = 1; kw = 32'hcf4f3c09;
      repeat (3) begin
         step(0, 0, '0, kr, kw);
         if (g_ks) begin kr = 0; kw = $urandom(); end
      end
      check("ks_vector", ks_result, 128'h8a84eb01);

      // all-zero state
      sr = 1; sd = '0;
      repeat (6) begin
         step(0, sr, sd, 0, '0);
         if (g_st) begin sr = 0; sd = rand128(); end
      end
      check("st_zero", st_result, 128'h63636363636363636363636363636363);

      // tie after reset, both held
      step(1, 0, '0, 0, '0);
      repeat (24) step(0, 1, rand128(), 1, $urandom());

      // back-to-back KS held, then ST joins
      step(1, 0, '0, 0, '0);
      repeat (8) step(0, 0, rand128(), 1, $urandom());
      repeat (12) step(0, 1, rand128(), 1, $urandom());

      // reset two cycles into an ST job
      step(1, 0, '0, 0, '0);
      step(0, 1, rand128(), 0, '0);
      step(0, 0, rand128(), 0, '0);
      step(1, 0, rand128(), 0, '0);
      step(0, 0, rand128(), 0, '0);
      check("abort_st_valid", st_valid, 1'b0);
      check("abort_busy",     busy,     1'b0);
      check("abort_result",   st_result, '0);

      // randomized traffic
      sr = 0; kr = 0;
      repeat (400) begin
         r = ($urandom_range(0, 59) == 0);
         if (!sr) sr = 1'($urandom_range(0, 1));
         if (!kr) kr = 1'($urandom_range(0, 1));
         step(r, sr, rand128(), kr, $urandom());
         if (g_st && $urandom_range(0, 2) != 0) sr = 0;
         if (g_ks && $urandom_range(0, 2) != 0) kr = 0;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
